// File: rtl/gemm_drain_pkg.sv
// -----------------------------------------------------------------------------
// gemm_drain_pkg
// Shared types and constants for the GeMM result drain (gemm_result_drain and
// gemm_drain_word_buffer).
//   - default geometry of an SRAM C word (kernels x lanes x element width)
//   - LanesPerWord: accumulators packed into one SRAM C word
//   - elem_t: one signed output element at the default width
//   - drain_state_e: drain FSM states
//   - prefetch_e: tracks the SRAM read latency for the staging register
// No ports (package).
// -----------------------------------------------------------------------------
package gemm_drain_pkg;

  localparam int DefOutDataWidth     = 32;
  localparam int DefNumKernels       = 4;
  localparam int DefNumParallelLanes = 4;
  localparam int LanesPerWord        = DefNumKernels * DefNumParallelLanes;

  typedef logic signed [DefOutDataWidth-1:0] elem_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_STREAM,
    ST_DONE
  } drain_state_e;

  // PF_ADDR: the next word address is on the bus this cycle.
  // PF_DATA: its read data is valid this cycle and is captured at the edge.
  typedef enum logic [1:0] {
    PF_IDLE,
    PF_ADDR,
    PF_DATA
  } prefetch_e;

endpackage

// File: rtl/gemm_drain_word_buffer.sv
// -----------------------------------------------------------------------------
// gemm_drain_word_buffer
// Holds the SRAM C word currently being serialized (word_p1) and the prefetched
// next word (stage_p1), and selects the active lane as the output element.
//
// Ports
//   clk_i      in   clock
//   load_i     in   capture rdata_i straight into the active word (first word)
//   capture_i  in   capture rdata_i into the staging word (prefetch)
//   promote_i  in   move the staging word into the active word (word boundary)
//   lane_i     in   lane index of the element to present
//   rdata_i    in   SRAM C read data, OutDataWidth*LaneCnt bits
//   elem_o     out  signed element word_p1[lane_i]
//
// Data registers carry no reset; the control path decides when they are valid.
// -----------------------------------------------------------------------------
module gemm_drain_word_buffer
  import gemm_drain_pkg::*;
#(
  parameter  int OutDataWidth = DefOutDataWidth,
  parameter  int LaneCnt      = LanesPerWord,
  localparam int LaneBits     = (LaneCnt > 1) ? $clog2(LaneCnt) : 1,
  localparam int WordW        = OutDataWidth * LaneCnt
) (
  input  logic                           clk_i,
  input  logic                           load_i,
  input  logic                           capture_i,
  input  logic                           promote_i,
  input  logic [LaneBits-1:0]            lane_i,
  input  logic [WordW-1:0]               rdata_i,
  output logic signed [OutDataWidth-1:0] elem_o
);

  logic [WordW-1:0] word_p1;
  logic [WordW-1:0] stage_p1;

  // ---- stage p1: word registers ----
  // With only two lanes per word the prefetch capture and the promotion can
  // land on the same edge; forwarding rdata_i keeps the promoted word correct.
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      word_p1 <= rdata_i;
    end else if (promote_i) begin
      word_p1 <= capture_i ? rdata_i : stage_p1;
    end
    if (capture_i) begin
      stage_p1 <= rdata_i;
    end
  end

  // ---- output: lane select ----
  assign elem_o = $signed(word_p1[int'(lane_i)*OutDataWidth +: OutDataWidth]);

endmodule

// File: rtl/gemm_result_drain.sv
// -----------------------------------------------------------------------------
// gemm_result_drain
// Reads packed GeMM result rows from SRAM C and serializes them into a
// row-major valid/ready stream of signed elements, lane 0 of each word first.
// After the initial fetch the stream sustains one element per cycle because
// the next word is prefetched into a staging register.
//
// Ports
//   clk_i           in   clock
//   rst_ni          in   synchronous active-low reset
//   start_i         in   begin a drain (honoured only when idle)
//   M_size_i        in   number of rows
//   N_size_i        in   number of columns (multiple of the lanes per word)
//   sram_c_addr_o   out  SRAM C read address (registered)
//   sram_c_rdata_i  in   SRAM C read data, valid one cycle after the address
//   out_data_o      out  stream element (signed), zero when not valid
//   out_valid_o     out  element valid
//   out_ready_i     in   consumer ready
//   out_last_o      out  final element of the matrix
//   busy_o          out  high whenever not idle
//   done_o          out  one-cycle completion pulse
//   checksum_o      out  wrapping sum of transferred elements; present only
//                        when GEMM_DRAIN_CHECKSUM_EN is defined
// -----------------------------------------------------------------------------
module gemm_result_drain
  import gemm_drain_pkg::*;
#(
  parameter  int OutDataWidth     = DefOutDataWidth,
  parameter  int NumKernels       = DefNumKernels,
  parameter  int NumParallelLanes = DefNumParallelLanes,
  parameter  int AddrWidth        = 12,
  parameter  int SizeAddrWidth    = 8,
  localparam int LaneCnt          = NumKernels * NumParallelLanes,
  localparam int WordW            = OutDataWidth * LaneCnt
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic [SizeAddrWidth-1:0]       M_size_i,
  input  logic [SizeAddrWidth-1:0]       N_size_i,
  output logic [AddrWidth-1:0]           sram_c_addr_o,
  input  logic [WordW-1:0]               sram_c_rdata_i,
  output logic signed [OutDataWidth-1:0] out_data_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic                           out_last_o,
  output logic                           busy_o,
  output logic                           done_o
`ifdef GEMM_DRAIN_CHECKSUM_EN
  ,
  output logic signed [OutDataWidth-1:0] checksum_o
`endif
);

  localparam int LaneBits = (LaneCnt > 1) ? $clog2(LaneCnt) : 1;
  localparam int TotW     = 2 * SizeAddrWidth;

  drain_state_e                   state_q, state_d;
  prefetch_e                      pf_q;
  logic [TotW-1:0]                total_d, total_q;
  logic [TotW-1:0]                word_ptr_q;
  logic [LaneBits-1:0]            lane_q;
  logic                           start_ok;
  logic                           xfer;
  logic                           lane_last;
  logic                           more_words;
  logic                           buf_load;
  logic                           promote;
  logic                           capture;
  logic signed [OutDataWidth-1:0] elem;

  // Words per row times rows; N is a whole number of words.
  assign total_d    = TotW'(M_size_i) * TotW'(N_size_i >> LaneBits);

  assign start_ok   = (state_q == ST_IDLE) && start_i;
  assign out_valid_o = (state_q == ST_STREAM);
  assign xfer       = out_valid_o && out_ready_i;
  assign lane_last  = (lane_q == LaneBits'(LaneCnt - 1));
  // word_ptr_q is the address of the word after the one being emitted, so
  // another word remains while it is still below the word count.
  assign more_words = (word_ptr_q < total_q);
  assign capture    = (state_q == ST_STREAM) && (pf_q == PF_DATA);

  assign out_last_o    = out_valid_o && lane_last && !more_words;
  assign out_data_o    = out_valid_o ? elem : '0;
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = (state_q == ST_DONE);
  assign sram_c_addr_o = AddrWidth'(word_ptr_q);

  // ---- FSM next state / controls ----
  always_comb begin
    state_d  = state_q;
    buf_load = 1'b0;
    promote  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = (total_d == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        buf_load = 1'b1;
        state_d  = ST_STREAM;
      end
      ST_STREAM: begin
        if (xfer && lane_last) begin
          if (more_words) begin
            promote = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---- stage p0: state, counters, address ----
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      pf_q       <= PF_IDLE;
      total_q    <= '0;
      word_ptr_q <= '0;
      lane_q     <= '0;
    end else begin
      state_q <= state_d;

      if (start_ok) begin
        total_q    <= total_d;
        word_ptr_q <= '0;
      end

      if (xfer) begin
        lane_q <= lane_q + 1'b1;
      end

      if (state_q == ST_STREAM) begin
        if (pf_q == PF_ADDR) begin
          pf_q <= PF_DATA;
        end else if (pf_q == PF_DATA) begin
          pf_q <= PF_IDLE;
        end
      end

      // A new address goes out at this edge; its data is captured two
      // STREAM cycles later.
      if (buf_load) begin
        word_ptr_q <= TotW'(1);
        lane_q     <= '0;
        pf_q       <= PF_ADDR;
      end else if (promote) begin
        word_ptr_q <= word_ptr_q + 1'b1;
        pf_q       <= PF_ADDR;
      end
    end
  end

  gemm_drain_word_buffer #(
    .OutDataWidth (OutDataWidth),
    .LaneCnt      (LaneCnt)
  ) u_word_buffer (
    .clk_i     (clk_i),
    .load_i    (buf_load),
    .capture_i (capture),
    .promote_i (promote),
    .lane_i    (lane_q),
    .rdata_i   (sram_c_rdata_i),
    .elem_o    (elem)
  );

`ifdef GEMM_DRAIN_CHECKSUM_EN
  function automatic logic signed [OutDataWidth-1:0] wrap_add(
    input logic signed [OutDataWidth-1:0] acc,
    input logic signed [OutDataWidth-1:0] x
  );
    return acc + x;
  endfunction

  // ---- stage p1: checksum accumulator ----
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      checksum_o <= '0;
    end else if (start_ok) begin
      checksum_o <= '0;
    end else if (xfer) begin
      checksum_o <= wrap_add(checksum_o, elem);
    end
  end
`endif

endmodule

// File: tb/tb_gemm_result_drain.sv
// -----------------------------------------------------------------------------
// tb_gemm_result_drain
// Table-driven bench for gemm_result_drain: each record gives the sizes, SRAM
// content pattern, ready pattern and the hand-computed beat count, first-valid
// cycle, done cycle and checksum. Reset values and reset mid-stream are
// hand-written sequences. Checksum checks apply when GEMM_DRAIN_CHECKSUM_EN is
// defined.
// -----------------------------------------------------------------------------
module tb_gemm_result_drain;

  localparam int Lanes = 16;
  localparam int DW    = 32;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic [7:0]            m_size;
  logic [7:0]            n_size;
  logic [11:0]           addr;
  logic [Lanes*DW-1:0]   rdata;
  logic signed [DW-1:0]  data;
  logic                  valid;
  logic                  ready;
  logic                  last;
  logic                  busy;
  logic                  done;
`ifdef GEMM_DRAIN_CHECKSUM_EN
  logic signed [DW-1:0]  checksum;
`endif

  int checks   = 0;
  int failures = 0;
  int cur_tag  = 0;
  int pat_sel  = 0;

  gemm_result_drain dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .M_size_i       (m_size),
    .N_size_i       (n_size),
    .sram_c_addr_o  (addr),
    .sram_c_rdata_i (rdata),
    .out_data_o     (data),
    .out_valid_o    (valid),
    .out_ready_i    (ready),
    .out_last_o     (last),
    .busy_o         (busy),
    .done_o         (done)
`ifdef GEMM_DRAIN_CHECKSUM_EN
    ,
    .checksum_o     (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM C content: pattern 0 -> word*16+lane, 1 -> word*16+lane+1, 2 -> -1
  function automatic logic [31:0] mem_val(input int pat, input int word, input int lane);
    case (pat)
      0:       return 32'(word * 16 + lane);
      1:       return 32'(word * 16 + lane + 1);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Expected k-th stream element for each pattern (row-major order)
  function automatic int exp_val(input int pat, input int k);
    case (pat)
      0:       return k;
      1:       return k + 1;
      default: return -1;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int l = 0; l < Lanes; l++) begin
      rdata[l*DW +: DW] <= mem_val(pat_sel, int'(addr), l);
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s tag=%0d actual=%0d required=%0d", name, cur_tag, act, req);
    end
  endtask

  typedef struct {
    int         m;
    int         n;
    int         pat;
    logic [3:0] rpat;      // ready in cycle c is rpat[c % 4]
    int         restart;   // cycle at which a start (M=7) is pulsed while busy, 0 = none
    int         exp_beats;
    int         exp_first; // cycle of first valid after start, 0 = never
    int         exp_done;  // cycle of done_o after start
    int         exp_sum;
  } vec_t;

  vec_t vecs[7];

  task automatic run_drain(input vec_t v);
    int   beats;
    int   first_v;
    int   done_c;
    int   prev_d;
    logic prev_l;
    bit   stalled;
    bit   busy_ok;
    bit   got_done;
    beats = 0; first_v = 0; done_c = 0; prev_d = 0; prev_l = 1'b0;
    stalled = 1'b0; busy_ok = 1'b1; got_done = 1'b0;
    @(negedge clk);
    pat_sel = v.pat;
    m_size  = 8'(v.m);
    n_size  = 8'(v.n);
    start   = 1'b1;
    for (int c = 1; c <= 2000 && !got_done; c++) begin
      @(negedge clk);
      start = (c == v.restart);
      if (c == v.restart) m_size = 8'd7;
      ready = v.rpat[c % 4];
      if (!busy) busy_ok = 1'b0;
      if (valid) begin
        if (first_v == 0) first_v = c;
        if (stalled) begin
          check("stall_data", int'(data), prev_d);
          check("stall_last", int'(last), int'(prev_l));
        end
        if (ready) begin
          check("beat_val", int'(data), exp_val(v.pat, beats));
          check("beat_last", int'(last), int'(beats == v.exp_beats - 1));
          beats++;
        end
        stalled = !ready;
        prev_d  = int'(data);
        prev_l  = last;
      end else begin
        if (stalled) check("valid_held", 0, 1);
        stalled = 1'b0;
      end
      if (done) begin
        done_c   = c;
        got_done = 1'b1;
`ifdef GEMM_DRAIN_CHECKSUM_EN
        check("checksum", int'(checksum), v.exp_sum);
`endif
      end
    end
    start = 1'b0;
    check("done_seen", int'(got_done), 1);
    check("first_valid_cyc", first_v, v.exp_first);
    check("beat_count", beats, v.exp_beats);
    check("done_cyc", done_c, v.exp_done);
    check("busy_held", int'(busy_ok), 1);
    @(negedge clk);
    check("done_pulse_len", int'(done), 0);
    check("busy_after_done", int'(busy), 0);
`ifdef GEMM_DRAIN_CHECKSUM_EN
    check("checksum_hold", int'(checksum), v.exp_sum);
`endif
  endtask

  initial begin
    int  hs;
    bit  hit;
    bit  no_done;

    vecs[0] = '{m:4, n:64, pat:0, rpat:4'b1111, restart:0, exp_beats:256, exp_first:3, exp_done:259, exp_sum:32640};
    vecs[1] = '{m:1, n:16, pat:0, rpat:4'b0101, restart:0, exp_beats:16,  exp_first:3, exp_done:35,  exp_sum:120};
    vecs[2] = '{m:0, n:32, pat:0, rpat:4'b1111, restart:0, exp_beats:0,   exp_first:0, exp_done:1,   exp_sum:0};
    vecs[3] = '{m:5, n:0,  pat:0, rpat:4'b1111, restart:0, exp_beats:0,   exp_first:0, exp_done:1,   exp_sum:0};
    vecs[4] = '{m:3, n:16, pat:0, rpat:4'b1101, restart:0, exp_beats:48,  exp_first:3, exp_done:67,  exp_sum:1128};
    vecs[5] = '{m:1, n:16, pat:1, rpat:4'b1111, restart:8, exp_beats:16,  exp_first:3, exp_done:19,  exp_sum:136};
    vecs[6] = '{m:1, n:16, pat:2, rpat:4'b1111, restart:0, exp_beats:16,  exp_first:3, exp_done:19,  exp_sum:-16};

    rst_n = 1'b0; start = 1'b0; m_size = '0; n_size = '0; ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    cur_tag = 100;
    check("rst_addr",  int'(addr),  0);
    check("rst_data",  int'(data),  0);
    check("rst_valid", int'(valid), 0);
    check("rst_last",  int'(last),  0);
    check("rst_busy",  int'(busy),  0);
    check("rst_done",  int'(done),  0);
`ifdef GEMM_DRAIN_CHECKSUM_EN
    check("rst_checksum", int'(checksum), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      cur_tag = i;
      run_drain(vecs[i]);
    end

    // Reset mid-stream: M=2, N=32, reset once 10 beats have been accepted
    cur_tag = 200;
    pat_sel = 0; m_size = 8'd2; n_size = 8'd32; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs = 0; hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (valid && ready) hs++;
      if (hs == 10) hit = 1'b1;
      else @(negedge clk);
    end
    check("mid_reached_10", int'(hit), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_busy",  int'(busy),  0);
    check("mid_rst_done",  int'(done),  0);
`ifdef GEMM_DRAIN_CHECKSUM_EN
    check("mid_rst_checksum", int'(checksum), 0);
`endif
    rst_n = 1'b1;
    no_done = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done || valid || busy) no_done = 1'b0;
    end
    check("mid_rst_quiet", int'(no_done), 1);

    // Restart after the abandoned drain completes in full
    cur_tag = 201;
    run_drain('{m:2, n:32, pat:0, rpat:4'b1111, restart:0, exp_beats:64, exp_first:3, exp_done:67, exp_sum:2016});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gemm_result_drain.md
# gemm_result_drain

Output-side drain stage for `gemm_accelerator_top_nxnxn`. Once a GeMM completes, this block reads the packed result rows from SRAM C, where each word holds `NumKernels*NumParallelLanes` accumulators. It serializes them into a row-major stream of signed `OutDataWidth` elements over a valid/ready interface for the downstream host/DMA. A staging register prefetches the next word, so the stream runs at one element per cycle after the initial fetch.

## Interface
- `OutDataWidth`, 32: element width.
- `NumKernels`, 4: kernels per SRAM C word.
- `NumParallelLanes`, 4: lanes per kernel. `LanesPerWord = NumKernels*NumParallelLanes`, a power of two.
- `AddrWidth`, 12: SRAM C address width.
- `SizeAddrWidth`, 8: width of the M/N size inputs.
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset. Synchronous, active-low.
- `start_i`  in  1: begin drain; sampled only in IDLE.
- `M_size_i`  in  SizeAddrWidth: rows.
- `N_size_i`  in  SizeAddrWidth: columns; a multiple of LanesPerWord.
- `sram_c_addr_o`  out  AddrWidth: SRAM C read address.
- `sram_c_rdata_i`  in  OutDataWidth*LanesPerWord: SRAM C read data. Valid the cycle after the address is presented.
- `out_data_o`  out  OutDataWidth: stream element, signed.
- `out_valid_o`  out  1: element valid.
- `out_ready_i`  in  1: consumer ready.
- `out_last_o`  out  1: final element of the matrix.
- `busy_o`  out  1: high outside IDLE.
- `done_o`  out  1: one-cycle completion pulse.
- `checksum_o`  out  OutDataWidth: present only with the macro (see Configuration).

## Operation
- **Sizes.** On `start_i` in IDLE, latch M and N, with `W = N >> log2(LanesPerWord)` and `total = M*W`.
- **Word mapping.** Element (m,n) comes from word `m*W + n/LanesPerWord`, bits `[(n%LanesPerWord)*OutDataWidth +: OutDataWidth]`. Lane 0 is emitted first.
- **States:**
  - IDLE: on start → FETCH. If `total==0`, go to DONE instead.
  - FETCH: present address 0 for one cycle → LOAD.
  - LOAD: capture `sram_c_rdata_i` into the buffer, set lane=0, present address 1 → STREAM.
  - STREAM: emit `buffer[lane]`. On handshake, increment lane. After the last lane of a word:
    - if another word remains, move staging→buffer, lane=0, present the next address, stay in STREAM;
    - otherwise → DONE.
  - DONE: pulse `done_o` → IDLE.
- **Prefetch.** The staging register captures the next word exactly once, on the second STREAM cycle after the address was updated. LanesPerWord ≥ 2, so staging is always full before the buffer empties.
- **Handshake.** Transfer occurs when `out_valid_o && out_ready_i`. While valid and not ready, `out_data_o` and `out_last_o` hold stable. `out_valid_o` never drops without a transfer.
- **Ignored inputs.** `start_i` while busy is ignored. The size inputs are sampled only at start.
- **Reset.** A reset mid-operation, active on the edge where `rst_ni=0`, forces IDLE. No `done_o` is produced and partial output is abandoned.
- **Reset values.** `sram_c_addr_o=0`, `out_data_o=0`, `out_valid_o=0`, `out_last_o=0`, `busy_o=0`, `done_o=0`, `checksum_o=0`.

## Timing
- Start in cycle t: FETCH at t+1, LOAD at t+2, first `out_valid_o` at t+3.
- With `out_ready_i` held high: `total*LanesPerWord` beats on consecutive cycles with no bubbles at word boundaries.
- `done_o` rises the cycle after the last handshake. `busy_o` falls one cycle later.
- Zero size: `done_o` at t+1; `out_valid_o` is never asserted.

## Configuration
- `GEMM_DRAIN_CHECKSUM_EN` defined: adds `checksum_o`.
  - Wrapping 2's-complement sum of every transferred element.
  - Cleared on accepted start.
  - Final and stable from the `done_o` cycle until the next start.
- Undefined: the port and accumulator are absent; all other behaviour is identical.

## Structure
- Package `gemm_drain_pkg`: the state enum (IDLE, FETCH, LOAD, STREAM, DONE), the `LanesPerWord` constant, and an element typedef.
- Sub-module `gemm_drain_word_buffer`: buffer and staging registers, the lane mux, and the capture/promote controls.
- The top holds the FSM, counters and address generation.

## Test plan
- **Full stream.** M=4, N=64; SRAM word i lane l = i*16+l; ready held 1. Expect first valid 3 cycles after start, then 256 gap-free beats with values 0..255. `out_last_o` only on value 255; `done_o` on the next cycle.
- **Backpressure.** M=1, N=16; ready toggles 1,0,1,0. Expect data stable while stalled, exactly 16 transfers with values 0..15, and no duplicates.
- **Zero size.** M=0, N=32. Expect `done_o` one cycle after start and no valid. Then N=0, M=5 gives the same result.
- **Reset mid-stream.** M=2, N=32; drop `rst_ni` after 10 beats. Expect valid=0 and busy=0 the next cycle, with no `done_o`. A restart then completes all 64 beats.
- **Start while busy, plus checksum.** Pulse start with M=7 mid-drain of a 1×16 run. Expect it to be ignored (16 beats). With `GEMM_DRAIN_CHECKSUM_EN` and values 1..16, expect `checksum_o`=136; with value -1 ×16, expect -16.
